decode_stage: RTL and testbench

Parametrised pipelined LEGv8 instruction-decode stage. Accepts a fetched instruction and PC, reads two operands from an internal 2R1W register file with a hardwired zero register, and generates a format-dependent sign-extended immediate. Results go into a one-entry ID/EX pipeline register with valid/ready handshake, flush, and writeback forwarding. Sits between fetch and the execution stage. The writeback port is driven from the memory/writeback stage.

---
 rtl/decode_pkg.sv | 50 +++++
 rtl/decode_stage_reg_file.sv | 44 ++++
 rtl/decode_stage.sv | 128 ++++++++++++
 tb/tb_decode_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the LEGv8 decode stage: opcode constants, immediate
// formats and the immediate-extraction helpers.
package decode_pkg;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_D,
    FMT_CB,
    FMT_B
  } imm_fmt_e;

  function automatic imm_fmt_e imm_format(logic [31:0] instr);
    if (instr[31:26] == OP_B) return FMT_B;
    if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) return FMT_CB;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) return FMT_D;
    if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) return FMT_I;
    return FMT_R;
  endfunction

  // Second read port takes Rt instead of Rm for stores and compare-branches.
  function automatic logic is_reg2loc(logic [31:0] instr);
    return (instr[31:21] == OP_STUR) || (instr[31:24] == OP_CBZ) ||
           (instr[31:24] == OP_CBNZ);
  endfunction

  // Every immediate fits in 32 bits with correct sign, so callers only need a
  // signed widening to reach the datapath width.
  function automatic logic [31:0] imm_extract(logic [31:0] instr);
    logic [31:0] imm;
    imm = '0;
    case (imm_format(instr))
      FMT_B:   imm = {{4{instr[25]}}, instr[25:0], 2'b00};
      FMT_CB:  imm = {{11{instr[23]}}, instr[23:5], 2'b00};
      FMT_D:   imm = {{23{instr[20]}}, instr[20:12]};
      FMT_I:   imm = {20'd0, instr[21:10]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file with a hardwired zero register and a
// write-first bypass from the write port to both read ports.
module reg_file #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = NREGS - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_live;

  assign wr_live = we && (waddr != ZeroIdx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_live) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (raddr1 == ZeroIdx)                    rdata1 = '0;
    else if (wr_live && (waddr == raddr1))    rdata1 = wdata;
    if (raddr2 == ZeroIdx)                    rdata2 = '0;
    else if (wr_live && (waddr == raddr2))    rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// LEGv8 instruction-decode stage: register read, immediate generation and a
// one-entry ID/EX register with valid/ready handshake, flush and forwarding.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = NREGS - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instr,
  input  logic [XLEN-1:0]          if_pc,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [XLEN-1:0]          ex_pc,
  output logic [31:0]              ex_instr,
  output logic [XLEN-1:0]          ex_rd1,
  output logic [XLEN-1:0]          ex_rd2,
  output logic [XLEN-1:0]          ex_imm,
  output logic [$clog2(NREGS)-1:0] ex_src1,
  output logic [$clog2(NREGS)-1:0] ex_src2
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [AW-1:0]   src1_q, src1_d, src2_q, src2_d;

  logic            load;
  logic [AW-1:0]   src1, src2;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            wb_live;

  assign if_ready = !valid_q || ex_ready;
  assign load     = if_valid && if_ready && !flush;
  assign wb_live  = wb_en && (wb_addr != ZeroIdx);
  assign src1     = AW'(if_instr[9:5]);
  assign src2     = is_reg2loc(if_instr) ? AW'(if_instr[4:0]) : AW'(if_instr[20:16]);

  reg_file #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    src1_d  = src1_q;
    src2_d  = src2_q;

    if (flush)         valid_d = 1'b0;
    else if (load)     valid_d = 1'b1;
    else if (ex_ready) valid_d = 1'b0;

    if (load) begin
      pc_d    = if_pc;
      instr_d = if_instr;
      rd1_d   = rdata1;
      rd2_d   = rdata2;
      imm_d   = XLEN'($signed(imm_extract(if_instr)));
      src1_d  = src1;
      src2_d  = src2;
    end else begin
      // Keep held operands current while EX is stalled.
      if (wb_live && (wb_addr == src1_q)) rd1_d = wb_data;
      if (wb_live && (wb_addr == src2_q)) rd2_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_pc    = pc_q;
  assign ex_instr = instr_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_src1  = src1_q;
  assign ex_src2  = src2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded LEGv8 instructions with
// hand-computed operands and immediates.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_pc;
  logic [31:0] ex_instr;
  logic [63:0] ex_rd1;
  logic [63:0] ex_rd2;
  logic [63:0] ex_imm;
  logic [4:0]  ex_src1;
  logic [4:0]  ex_src2;

  int n_checks = 0;
  int n_errors = 0;

  // ADD X5,X3,X3 / LDUR X1,[X7,#-8] / CBZ X2,#-4 / ADDI X0,X31,#4095
  // STUR X3,[X7,#16] / B #4
  localparam logic [31:0] I_ADD  = {11'b10001011000, 5'd3, 6'd0, 5'd3, 5'd5};
  localparam logic [31:0] I_LDUR = {11'b11111000010, 9'h1F8, 2'b00, 5'd7, 5'd1};
  localparam logic [31:0] I_CBZ  = {8'b10110100, 19'h7FFFF, 5'd2};
  localparam logic [31:0] I_ADDI = {10'b1001000100, 12'hFFF, 5'd31, 5'd0};
  localparam logic [31:0] I_STUR = {11'b11111000000, 9'd16, 2'b00, 5'd7, 5'd3};
  localparam logic [31:0] I_B    = {6'b000101, 26'd1};

  decode_stage dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .flush    (flush),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_pc    (ex_pc),
    .ex_instr (ex_instr),
    .ex_rd1   (ex_rd1),
    .ex_rd2   (ex_rd2),
    .ex_imm   (ex_imm),
    .ex_src1  (ex_src1),
    .ex_src2  (ex_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [63:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_instr = '0; if_pc = '0;
    flush = 1'b0; ex_ready = 1'b0;
    wb(1'b0, 5'd0, 64'd0);
    #1;
    check("rst_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_pc", ex_pc, 64'd0);
    check("rst_rd1", ex_rd1, 64'd0);
    tick; tick;
    rst = 1'b0;
    #1;
    check("rst_if_ready", {63'd0, if_ready}, 64'd1);

    wb(1'b1, 5'd3, 64'h1234); tick;
    wb(1'b1, 5'd2, 64'd9);    tick;
    wb(1'b0, 5'd0, 64'd0);

    // Basic R-format
    ex_ready = 1'b1;
    issue(I_ADD, 64'h100); tick;
    check("add_valid", {63'd0, ex_valid}, 64'd1);
    check("add_pc", ex_pc, 64'h100);
    check("add_rd1", ex_rd1, 64'h1234);
    check("add_rd2", ex_rd2, 64'h1234);
    check("add_imm", ex_imm, 64'd0);
    check("add_instr", {32'd0, ex_instr}, {32'd0, I_ADD});

    // Load with same-cycle writeback bypass
    issue(I_LDUR, 64'h104); wb(1'b1, 5'd7, 64'hAA); tick;
    wb(1'b0, 5'd0, 64'd0);
    check("ldur_rd1", ex_rd1, 64'hAA);
    check("ldur_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_src1", {59'd0, ex_src1}, 64'd7);

    // CBZ: Rn field is X31; a same-cycle write there must not bypass
    issue(I_CBZ, 64'h108); wb(1'b1, 5'd31, 64'h55); tick;
    check("cbz_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("cbz_rd2", ex_rd2, 64'd9);
    check("cbz_src2", {59'd0, ex_src2}, 64'd2);
    check("cbz_rd1_zero", ex_rd1, 64'd0);

    issue(I_ADDI, 64'h10C); tick;
    wb(1'b0, 5'd0, 64'd0);
    check("addi_rd1", ex_rd1, 64'd0);
    check("addi_imm", ex_imm, 64'hFFF);
    check("addi_src1", {59'd0, ex_src1}, 64'd31);

    issue(I_STUR, 64'h110); tick;
    check("stur_rd1", ex_rd1, 64'hAA);
    check("stur_rd2", ex_rd2, 64'h1234);
    check("stur_imm", ex_imm, 64'd16);
    check("stur_src2", {59'd0, ex_src2}, 64'd3);

    issue(I_B, 64'h114); tick;
    check("b_imm", ex_imm, 64'd4);

    // Stall three cycles holding B (src1=src2=X0); forward a write to X0
    ex_ready = 1'b0;
    issue(I_ADD, 64'h118);
    #1;
    check("stall_if_ready", {63'd0, if_ready}, 64'd0);
    wb(1'b1, 5'd0, 64'h77); tick;
    wb(1'b0, 5'd0, 64'd0);
    check("stall_pc0", ex_pc, 64'h114);
    check("stall_fwd_rd1", ex_rd1, 64'h77);
    check("stall_fwd_rd2", ex_rd2, 64'h77);
    tick;
    check("stall_pc1", ex_pc, 64'h114);
    check("stall_imm1", ex_imm, 64'd4);
    tick;
    check("stall_pc2", ex_pc, 64'h114);
    check("stall_valid2", {63'd0, ex_valid}, 64'd1);
    ex_ready = 1'b1;
    #1;
    check("resume_if_ready", {63'd0, if_ready}, 64'd1);
    tick;
    check("resume_pc", ex_pc, 64'h118);
    check("resume_rd1", ex_rd1, 64'h1234);

    // Flush beats both hold and load
    ex_ready = 1'b0;
    flush = 1'b1;
    issue(I_ADDI, 64'h11C); tick;
    check("flush_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;
    if_valid = 1'b0;
    tick;
    check("flush_dropped_valid", {63'd0, ex_valid}, 64'd0);
    check("flush_dropped_pc", ex_pc, 64'h118);

    // Drain: ex_ready with nothing loading clears valid
    issue(I_ADD, 64'h11E); ex_ready = 1'b1; tick;
    if_valid = 1'b0; tick;
    check("drain_valid", {63'd0, ex_valid}, 64'd0);

    // Reset while stalled
    ex_ready = 1'b0;
    issue(I_ADDI, 64'h120); tick;
    check("pre_rst_pc", ex_pc, 64'h120);
    if_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, ex_valid}, 64'd0);
    check("midrst_pc", ex_pc, 64'd0);
    check("midrst_instr", {32'd0, ex_instr}, 64'd0);
    check("midrst_imm", ex_imm, 64'd0);
    tick;
    rst = 1'b0;
    ex_ready = 1'b1;
    issue(I_ADD, 64'h124); tick;
    check("post_rst_valid", {63'd0, ex_valid}, 64'd1);
    check("post_rst_rf_cleared", ex_rd1, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
